// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, assembles one- and two-word instructions
// into the IF/ID register, and handles redirects and interrupt entry.
module fetch_stage #(
  parameter int                 INST_WIDTH   = 16,
  parameter int                 PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 32,
  parameter logic [PC_WIDTH-1:0] INT_PC      = 0,
  parameter int                 IMM_FLAG_BIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_data,
  input  logic                  stall,
  input  logic                  redirect_en,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  int_req,
  output logic                  if_id_valid,
  output logic [INST_WIDTH-1:0] if_id_instr,
  output logic [INST_WIDTH-1:0] if_id_imm,
  output logic [PC_WIDTH-1:0]   if_id_pc_next,
  output logic                  int_taken,
  output logic [PC_WIDTH-1:0]   int_return_pc
);

  // state | meaning
  // FETCH | expecting an opcode word at pc
  // IMM   | opcode held, expecting its immediate word at pc
  typedef enum logic {FETCH, IMM} state_t;

  state_t                state, state_nxt;
  logic [PC_WIDTH-1:0]   pc, pc_nxt, pc_inc;
  logic [INST_WIDTH-1:0] held, held_nxt;
  logic                  int_pending, pend_nxt;
  logic                  valid_nxt, taken_nxt;
  logic [INST_WIDTH-1:0] instr_nxt, imm_nxt;
  logic [PC_WIDTH-1:0]   pcn_nxt, ret_nxt;

  assign imem_addr = pc;
  assign pc_inc    = pc + PC_WIDTH'(1);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    held_nxt  = held;
    pend_nxt  = int_pending | int_req;
    valid_nxt = if_id_valid;
    instr_nxt = if_id_instr;
    imm_nxt   = if_id_imm;
    pcn_nxt   = if_id_pc_next;
    taken_nxt = 1'b0;
    ret_nxt   = int_return_pc;

    if (redirect_en) begin
      pc_nxt    = redirect_pc;
      state_nxt = FETCH;
      held_nxt  = '0;
      valid_nxt = 1'b0;
    end else if (stall) begin
      // everything holds; int_taken already defaults low
    end else if (state == FETCH && int_pending) begin
      // only entered from FETCH so a two-word instruction is never split
      taken_nxt = 1'b1;
      ret_nxt   = pc;
      pc_nxt    = INT_PC;
      valid_nxt = 1'b0;
      pend_nxt  = 1'b0;
    end else if (state == FETCH) begin
      pc_nxt = pc_inc;
      if (imem_data[IMM_FLAG_BIT]) begin
        held_nxt  = imem_data;
        state_nxt = IMM;
        valid_nxt = 1'b0;
      end else begin
        valid_nxt = 1'b1;
        instr_nxt = imem_data;
        imm_nxt   = '0;
        pcn_nxt   = pc_inc;
      end
    end else begin
      valid_nxt = 1'b1;
      instr_nxt = held;
      imm_nxt   = imem_data;
      pcn_nxt   = pc_inc;
      pc_nxt    = pc_inc;
      state_nxt = FETCH;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      held          <= '0;
      int_pending   <= 1'b0;
      if_id_valid   <= 1'b0;
      if_id_instr   <= '0;
      if_id_imm     <= '0;
      if_id_pc_next <= '0;
      int_taken     <= 1'b0;
      int_return_pc <= '0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      held          <= held_nxt;
      int_pending   <= pend_nxt;
      if_id_valid   <= valid_nxt;
      if_id_instr   <= instr_nxt;
      if_id_imm     <= imm_nxt;
      if_id_pc_next <= pcn_nxt;
      int_taken     <= taken_nxt;
      int_return_pc <= ret_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small ROM model feeds imem_data and each
// cycle's IF/ID, PC and interrupt outputs are compared with hand-derived values.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        int_req;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_imm;
  logic [31:0] if_id_pc_next;
  logic        int_taken;
  logic [31:0] int_return_pc;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .int_req       (int_req),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_imm     (if_id_imm),
    .if_id_pc_next (if_id_pc_next),
    .int_taken     (int_taken),
    .int_return_pc (int_return_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [31:0] a);
    case (a)
      32'd0:          rom = 16'h0055;
      32'd32:         rom = 16'h0011;
      32'd33:         rom = 16'h0022;
      32'd34:         rom = 16'h0033;
      32'd40:         rom = 16'h8005;
      32'd41:         rom = 16'h1234;
      32'd42:         rom = 16'h0044;
      32'd100:        rom = 16'h0066;
      32'd101:        rom = 16'h0077;
      32'hFFFF_FFFF:  rom = 16'h0099;
      default:        rom = 16'h0000;
    endcase
  endfunction

  always_comb imem_data = rom(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [15:0] ins,
                            input logic [15:0] imm, input logic [31:0] pcn);
    check_eq({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    if (v) begin
      check_eq({tag, ".instr"},   32'(if_id_instr), 32'(ins));
      check_eq({tag, ".imm"},     32'(if_id_imm),   32'(imm));
      check_eq({tag, ".pc_next"}, if_id_pc_next,    pcn);
    end
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_en = 1'b1;
    redirect_pc = target;
    step();
    redirect_en = 1'b0;
    check_eq("redir_addr", imem_addr, target);
    check_eq("redir_valid", 32'(if_id_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0; int_req = 1'b0;
    step();
    step();
    check_eq("rst_addr", imem_addr, 32'd32);
    check_eq("rst_valid", 32'(if_id_valid), 32'd0);
    check_eq("rst_instr", 32'(if_id_instr), 32'd0);
    check_eq("rst_imm", 32'(if_id_imm), 32'd0);
    check_eq("rst_pcn", if_id_pc_next, 32'd0);
    check_eq("rst_taken", 32'(int_taken), 32'd0);
    check_eq("rst_ret", int_return_pc, 32'd0);

    // free-running one-word fetch
    reset = 1'b0;
    step();
    check_eq("run1_addr", imem_addr, 32'd33);
    check_ifid("run1", 1'b1, 16'h0011, 16'h0000, 32'd33);
    step();
    check_eq("run2_addr", imem_addr, 32'd34);
    check_ifid("run2", 1'b1, 16'h0022, 16'h0000, 32'd34);

    // stall after a valid instruction holds everything
    stall = 1'b1;
    step();
    stall = 1'b0;
    check_eq("stallv_addr", imem_addr, 32'd34);
    check_ifid("stallv", 1'b1, 16'h0022, 16'h0000, 32'd34);

    // two-word instruction with a 3-cycle stall inside IMM
    do_redirect(32'd40);
    step();
    check_eq("bub_addr", imem_addr, 32'd41);
    check_eq("bub_valid", 32'(if_id_valid), 32'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_addr", imem_addr, 32'd41);
      check_eq("stall_valid", 32'(if_id_valid), 32'd0);
    end
    stall = 1'b0;
    step();
    check_eq("two_addr", imem_addr, 32'd42);
    check_ifid("two", 1'b1, 16'h8005, 16'h1234, 32'd42);

    // interrupt pulse while in IMM is deferred to the next FETCH
    do_redirect(32'd40);
    step();
    check_eq("irq_imm_addr", imem_addr, 32'd41);
    int_req = 1'b1;
    step();
    int_req = 1'b0;
    check_eq("irq_defer_taken", 32'(int_taken), 32'd0);
    check_eq("irq_defer_addr", imem_addr, 32'd42);
    check_ifid("irq_pair", 1'b1, 16'h8005, 16'h1234, 32'd42);
    step();
    check_eq("irq_taken", 32'(int_taken), 32'd1);
    check_eq("irq_ret", int_return_pc, 32'd42);
    check_eq("irq_addr", imem_addr, 32'd0);
    check_eq("irq_valid", 32'(if_id_valid), 32'd0);
    step();
    check_eq("irq_pulse_end", 32'(int_taken), 32'd0);
    check_eq("irq_vec_addr", imem_addr, 32'd1);
    check_ifid("irq_vec", 1'b1, 16'h0055, 16'h0000, 32'd1);

    // redirect wins over stall while in IMM; held opcode is discarded
    do_redirect(32'd40);
    step();
    check_eq("rs_imm_addr", imem_addr, 32'd41);
    stall = 1'b1;
    do_redirect(32'd100);
    stall = 1'b0;
    step();
    check_eq("rs_addr", imem_addr, 32'd101);
    check_ifid("rs", 1'b1, 16'h0066, 16'h0000, 32'd101);

    // PC wrap
    do_redirect(32'hFFFF_FFFF);
    step();
    check_eq("wrap_addr", imem_addr, 32'd0);
    check_ifid("wrap", 1'b1, 16'h0099, 16'h0000, 32'd0);

    // reset in the middle of IMM
    do_redirect(32'd40);
    step();
    check_eq("rimm_addr", imem_addr, 32'd41);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rimm_rst_addr", imem_addr, 32'd32);
    check_eq("rimm_rst_valid", 32'(if_id_valid), 32'd0);
    step();
    check_eq("rimm_after_addr", imem_addr, 32'd33);
    check_ifid("rimm_after", 1'b1, 16'h0011, 16'h0000, 32'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
